dma_rx_packer: RTL and testbench

Receive-side packer between the UART byte receiver and the DMA engine's cache-write path. It assembles the 8-bit UART byte stream into 18-bit data-cache words, three bytes per word, little-endian. Words are buffered in a small FIFO and presented to the DMA with a valid/ready handshake. It flags malformed words, inter-byte timeouts and FIFO overflow, because the UART link has no backpressure.

---
 rtl/dma_pkg.sv | 16 +
 rtl/dma_word_fifo.sv | 58 +++++
 rtl/dma_rx_packer.sv | 104 ++++++++++
 tb/tb_dma_rx_packer.sv | 198 +++++++++++++++++++
 4 files changed

// File: rtl/dma_pkg.sv
// Shared widths and types for the DMA receive-side byte packer.
package dma_pkg;

    localparam int unsigned WORD_W         = 18;
    localparam int unsigned BYTE_W         = 8;
    localparam int unsigned BYTES_PER_WORD = 3;

    typedef enum logic [1:0] {
        S_B0 = 2'd0,
        S_B1 = 2'd1,
        S_B2 = 2'd2
    } rx_pack_state_t;

    typedef logic [WORD_W-1:0] dma_word_t;

endpackage

// File: rtl/dma_word_fifo.sv
// Synchronous show-ahead FIFO; a push into a full FIFO succeeds only alongside a pop.
module dma_word_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 18
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign pop_ok   = pop && !empty;
    assign push_ok  = push && (!full || pop_ok);
    assign pop_data = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dma_rx_packer.sv
// Packs the UART byte stream into 18-bit little-endian cache words and queues them for DMA.
module dma_rx_packer
    import dma_pkg::*;
#(
    parameter int unsigned DEPTH          = 4,
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rx_valid,
    input  logic [BYTE_W-1:0] rx_byte,
    output logic              word_valid,
    output logic [WORD_W-1:0] word,
    input  logic              word_ready,
    output logic              fmt_err,
    output logic              timeout_err,
    output logic              ovf_err,
    output logic [15:0]       word_count
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    rx_pack_state_t    state;
    logic [BYTE_W-1:0] lo_byte;
    logic [BYTE_W-1:0] hi_byte;
    logic [CNT_W-1:0]  idle_cnt;
    logic              push;
    dma_word_t         push_word;
    logic              fifo_full;
    logic              fifo_empty;
    logic              push_accepted;
    logic              expire;

    assign push          = rx_valid && (state == S_B2);
    assign push_word     = {rx_byte[1:0], hi_byte, lo_byte};
    assign push_accepted = push && (!fifo_full || word_ready);
    // The current idle cycle is the TIMEOUT_CYCLES-th one; a byte arriving now wins.
    assign expire        = (state != S_B0) && !rx_valid
                           && (idle_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign word_valid    = !fifo_empty;

    dma_word_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_word),
        .pop       (word_ready),
        .pop_data  (word),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= S_B0;
            lo_byte     <= '0;
            hi_byte     <= '0;
            idle_cnt    <= '0;
            fmt_err     <= 1'b0;
            timeout_err <= 1'b0;
            ovf_err     <= 1'b0;
            word_count  <= '0;
        end else begin
            if (rx_valid) begin
                idle_cnt <= '0;
                case (state)
                    S_B0: begin
                        lo_byte <= rx_byte;
                        state   <= S_B1;
                    end
                    S_B1: begin
                        hi_byte <= rx_byte;
                        state   <= S_B2;
                    end
                    S_B2: begin
                        if (rx_byte[7:2] != '0) begin
                            fmt_err <= 1'b1;
                        end
                        state <= S_B0;
                    end
                    default: state <= S_B0;
                endcase
            end else if (state != S_B0) begin
                if (expire) begin
                    state       <= S_B0;
                    idle_cnt    <= '0;
                    timeout_err <= 1'b1;
                end else begin
                    idle_cnt <= idle_cnt + 1'b1;
                end
            end

            if (push_accepted) begin
                word_count <= word_count + 16'd1;
            end else if (push) begin
                ovf_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_dma_rx_packer.sv
// Directed self-checking bench for dma_rx_packer with a shortened timeout.
module tb_dma_rx_packer;

    localparam int unsigned TMO = 64;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = '0;
    logic        word_valid;
    logic [17:0] word;
    logic        word_ready = 1'b0;
    logic        fmt_err;
    logic        timeout_err;
    logic        ovf_err;
    logic [15:0] word_count;

    int unsigned total = 0;
    int unsigned bad = 0;

    // Burst table: lo, hi, third byte and the expected packed word.
    logic [7:0]  b_lo  [5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA4};
    logic [7:0]  b_hi  [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h14};
    logic [7:0]  b_top [5] = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h00};
    logic [17:0] w_exp [5] = '{18'h010A0, 18'h111A1, 18'h212A2, 18'h313A3, 18'h014A4};

    dma_rx_packer #(
        .DEPTH          (4),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_valid    (rx_valid),
        .rx_byte     (rx_byte),
        .word_valid  (word_valid),
        .word        (word),
        .word_ready  (word_ready),
        .fmt_err     (fmt_err),
        .timeout_err (timeout_err),
        .ovf_err     (ovf_err),
        .word_count  (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_byte  = b;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset    = 1'b0;
        rx_valid = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic send_word(input int unsigned i);
        send(b_lo[i]);
        send(b_hi[i]);
        send(b_top[i]);
    endtask

    initial begin
        do_reset();
        check_eq("rst_valid", 32'(word_valid), 32'd0);
        check_eq("rst_word", 32'(word), 32'd0);
        check_eq("rst_flags", {29'd0, fmt_err, timeout_err, ovf_err}, 32'd0);
        check_eq("rst_count", 32'(word_count), 32'd0);

        // Basic packing, consumer always ready
        word_ready = 1'b1;
        send(8'h34);
        send(8'h12);
        check_eq("partial_valid", 32'(word_valid), 32'd0);
        send(8'h02);
        check_eq("t1_valid", 32'(word_valid), 32'd1);
        check_eq("t1_word", 32'(word), 32'h21234);
        check_eq("t1_count", 32'(word_count), 32'd1);
        check_eq("t1_flags", {29'd0, fmt_err, timeout_err, ovf_err}, 32'd0);
        tick();
        check_eq("t1_popped", 32'(word_valid), 32'd0);
        check_eq("t1_empty_word", 32'(word), 32'd0);

        // Malformed third byte
        send(8'hFF);
        send(8'hFF);
        send(8'hFF);
        check_eq("t2_word", 32'(word), 32'h3FFFF);
        check_eq("t2_fmt", 32'(fmt_err), 32'd1);
        check_eq("t2_count", 32'(word_count), 32'd2);
        tick();

        // Timeout discards partial word
        do_reset();
        check_eq("t3_fmt_cleared", 32'(fmt_err), 32'd0);
        word_ready = 1'b0;
        send(8'hAA);
        send(8'hBB);
        repeat (TMO - 1) tick();
        check_eq("t3_before_expiry", 32'(timeout_err), 32'd0);
        tick();
        check_eq("t3_timeout", 32'(timeout_err), 32'd1);
        send(8'h01);
        send(8'h02);
        send(8'h00);
        check_eq("t3_word", 32'(word), 32'h00201);
        check_eq("t3_count", 32'(word_count), 32'd1);
        word_ready = 1'b1;
        tick();
        check_eq("t3_only_word", 32'(word_valid), 32'd0);

        // Byte on the expiry cycle wins
        do_reset();
        word_ready = 1'b0;
        send(8'hAA);
        send(8'hBB);
        repeat (TMO - 1) tick();
        send(8'h03);
        check_eq("t3b_no_timeout", 32'(timeout_err), 32'd0);
        check_eq("t3b_word", 32'(word), 32'h3BBAA);
        check_eq("t3b_count", 32'(word_count), 32'd1);

        // Overflow with DMA stalled
        do_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(i);
        check_eq("t4_count4", 32'(word_count), 32'd4);
        check_eq("t4_ovf_before", 32'(ovf_err), 32'd0);
        send_word(4);
        check_eq("t4_ovf", 32'(ovf_err), 32'd1);
        check_eq("t4_count_hold", 32'(word_count), 32'd4);
        check_eq("t4_fmt", 32'(fmt_err), 32'd0);
        word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check_eq($sformatf("t4_drain%0d", i), 32'(word), 32'(w_exp[i]));
            tick();
        end
        check_eq("t4_drained", 32'(word_valid), 32'd0);
        check_eq("t4_count_after", 32'(word_count), 32'd4);

        // Full FIFO with simultaneous pop on the 5th push
        do_reset();
        word_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_word(i);
        send(b_lo[4]);
        send(b_hi[4]);
        word_ready = 1'b1;
        send(b_top[4]);
        check_eq("t5_ovf", 32'(ovf_err), 32'd0);
        check_eq("t5_count", 32'(word_count), 32'd5);
        for (int i = 1; i < 5; i++) begin
            check_eq($sformatf("t5_drain%0d", i), 32'(word), 32'(w_exp[i]));
            tick();
        end
        check_eq("t5_drained", 32'(word_valid), 32'd0);

        // Reset mid-word leaves no stale bytes
        word_ready = 1'b0;
        send(8'hAA);
        send(8'hBB);
        do_reset();
        check_eq("t6_rst_count", 32'(word_count), 32'd0);
        send(8'h01);
        send(8'h00);
        check_eq("t6_partial", 32'(word_valid), 32'd0);
        send(8'h00);
        check_eq("t6_valid", 32'(word_valid), 32'd1);
        check_eq("t6_word", 32'(word), 32'h00001);
        check_eq("t6_count", 32'(word_count), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
